// File: rtl/cobra_pkg.sv
// Shared playfield geometry, cell coordinate types and food spawner states.
// SCAN exists only when FOOD_FALLBACK_SCAN_EN is defined.
package cobra_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;

    typedef logic [5:0] cell_x_t;
    typedef logic [4:0] cell_y_t;

`ifdef FOOD_FALLBACK_SCAN_EN
    typedef enum logic [2:0] {IDLE, WAIT_X, WAIT_Y, CHECK, SCAN} spawner_state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_X, WAIT_Y, CHECK} spawner_state_t;
`endif

endpackage

// File: rtl/sample_timer.sv
// Reloadable countdown pacing consumers of the LFSR word; tick_o is high while the count is zero.
// load_i restarts a full PERIOD, so a reload on every tick yields one tick per PERIOD cycles.
module sample_timer #(
    parameter int PERIOD = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic tick_o
);

    localparam int            CW     = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/food_spawner.sv
// Rejection-samples LFSR words into a free food cell; best case 2*SAMPLE_PERIOD+1+ack-delay cycles.
// occ_req holds until occ_ack, spawn_req is ignored while busy; FOOD_FALLBACK_SCAN_EN adds a row-major scan fallback.
module food_spawner #(
    parameter int GRID_W        = cobra_pkg::GRID_W,
    parameter int GRID_H        = cobra_pkg::GRID_H,
    parameter int SAMPLE_PERIOD = 10,
    parameter int MAX_TRIES     = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] rnd_i,
    input  logic       spawn_req_i,
    output logic       occ_req_o,
    output logic [5:0] occ_x_o,
    output logic [4:0] occ_y_o,
    input  logic       occ_ack_i,
    input  logic       occ_hit_i,
    output logic [5:0] food_x_o,
    output logic [4:0] food_y_o,
    output logic       food_valid_o,
    output logic       busy_o,
    output logic       spawn_done_o,
    output logic       spawn_fail_o
);

    import cobra_pkg::*;

    // One spare bit so a 64-wide or 32-high grid still compares correctly.
    localparam logic [6:0] X_LIM = 7'(GRID_W);
    localparam logic [5:0] Y_LIM = 6'(GRID_H);

    spawner_state_t state_q, state_d;
    cell_x_t        x_q, x_d, food_x_q, food_x_d;
    cell_y_t        y_q, y_d, food_y_q, food_y_d;
    logic [4:0]     tries_q, tries_d, tries_inc;
    logic           food_valid_q, food_valid_d;
    logic           done_q, done_d;
    logic           load, tick, reject;
    logic [3:0]     unused_rnd;

`ifdef FOOD_FALLBACK_SCAN_EN
    localparam cell_x_t X_LAST = cell_x_t'(GRID_W - 1);
    localparam cell_y_t Y_LAST = cell_y_t'(GRID_H - 1);
    logic scan_q, scan_d, fail_q, fail_d;
`else
    logic [4:0] unused_max;
    assign unused_max = 5'(MAX_TRIES);
`endif

    assign unused_rnd = rnd_i[9:6];
    assign tries_inc  = (tries_q == 5'd31) ? tries_q : tries_q + 5'd1;

    sample_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .tick_o  (tick)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        tries_d      = tries_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        done_d       = 1'b0;
        load         = 1'b0;
        reject       = 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
        scan_d       = scan_q;
        fail_d       = 1'b0;
`endif
        case (state_q)
            IDLE: if (spawn_req_i) begin
                state_d      = WAIT_X;
                load         = 1'b1;
                food_valid_d = 1'b0;
                tries_d      = '0;
`ifdef FOOD_FALLBACK_SCAN_EN
                scan_d       = 1'b0;
`endif
            end
            WAIT_X: if (tick) begin
                load = 1'b1;
                if ({1'b0, rnd_i[5:0]} >= X_LIM) begin
                    reject = 1'b1;
                end else begin
                    x_d     = rnd_i[5:0];
                    state_d = WAIT_Y;
                end
            end
            WAIT_Y: if (tick) begin
                load = 1'b1;
                if ({1'b0, rnd_i[4:0]} >= Y_LIM) begin
                    reject = 1'b1;
                end else begin
                    y_d     = rnd_i[4:0];
                    state_d = CHECK;
                end
            end
            CHECK: if (occ_ack_i) begin
                if (!occ_hit_i) begin
                    food_x_d     = x_q;
                    food_y_d     = y_q;
                    food_valid_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
`ifdef FOOD_FALLBACK_SCAN_EN
                else if (scan_q) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        fail_d       = 1'b1;
                        food_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 5'd1;
                        end else begin
                            x_d = x_q + 6'd1;
                        end
                        state_d = SCAN;
                    end
                end
`endif
                else begin
                    reject  = 1'b1;
                    load    = 1'b1;
                    state_d = WAIT_X;
                end
            end
`ifdef FOOD_FALLBACK_SCAN_EN
            // One idle cycle between scan queries keeps occ_req a clean per-cell pulse.
            SCAN: state_d = CHECK;
`endif
            default: state_d = IDLE;
        endcase

        if (reject) begin
            tries_d = tries_inc;
`ifdef FOOD_FALLBACK_SCAN_EN
            if (32'(tries_inc) >= MAX_TRIES) begin
                state_d = SCAN;
                scan_d  = 1'b1;
                x_d     = '0;
                y_d     = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            tries_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
            scan_q       <= 1'b0;
            fail_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tries_q      <= tries_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            done_q       <= done_d;
`ifdef FOOD_FALLBACK_SCAN_EN
            scan_q       <= scan_d;
            fail_q       <= fail_d;
`endif
        end
    end

    assign occ_req_o    = (state_q == CHECK);
    assign occ_x_o      = x_q;
    assign occ_y_o      = y_q;
    assign food_x_o     = food_x_q;
    assign food_y_o     = food_y_q;
    assign food_valid_o = food_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign spawn_done_o = done_q;
`ifdef FOOD_FALLBACK_SCAN_EN
    assign spawn_fail_o = fail_q;
`else
    assign spawn_fail_o = 1'b0;
`endif

endmodule

// File: doc/food_spawner.md
# food_spawner

Consumes the 10-bit pseudo-random word from the LFSR coordinate generator and turns it into a legal food cell on the 40×30 playfield (16-pixel cells on 640×480). On a spawn request it draws X and Y from successive LFSR words and rejects out-of-range values. It then asks the game-state logic whether the candidate cell is occupied by a snake, and publishes the accepted cell to the renderer and collision logic.

## Interface
Parameters:
- GRID_W, 40, playfield width in cells; must be ≤ 64.
- GRID_H, 30, playfield height in cells; must be ≤ 32.
- SAMPLE_PERIOD, 10, cycles between fresh LFSR words; matches the generator's output update rate.
- MAX_TRIES, 16, rejected candidates allowed before fallback. Used only with the macro.

Ports:
- Clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- rnd, in, 10: random word from the LFSR generator.
- spawn_req, in, 1: single-cycle request for a new food cell.
- occ_req, out, 1: occupancy query valid.
- occ_x, out, 6: queried cell X.
- occ_y, out, 5: queried cell Y.
- occ_ack, in, 1: occupancy answer valid.
- occ_hit, in, 1: queried cell is occupied; meaningful only when occ_ack=1.
- food_x, out, 6: current food X.
- food_y, out, 5: current food Y.
- food_valid, out, 1: food_x and food_y hold an accepted cell.
- busy, out, 1: spawn in progress.
- spawn_done, out, 1: one-cycle pulse when a cell is accepted.
- spawn_fail, out, 1: one-cycle pulse when the fallback scan finds no free cell.

## Operation
- States: IDLE, WAIT_X, WAIT_Y, CHECK, SCAN (SCAN exists only with the macro).
- IDLE: spawn_req=1 enters WAIT_X, loads the wait counter with SAMPLE_PERIOD-1, sets busy=1, clears food_valid and tries.
- While busy=1, spawn_req is ignored. No queuing.
- WAIT_X: counter decrements each cycle. At 0:
  - x_cand = rnd[5:0].
  - If x_cand ≥ GRID_W: reject, tries+1, reload the counter, stay in WAIT_X.
  - Otherwise: reload the counter and go to WAIT_Y.
- WAIT_Y: same countdown. At 0:
  - y_cand = rnd[4:0].
  - If y_cand ≥ GRID_H: reject, tries+1, stay in WAIT_Y; the accepted x_cand is kept.
  - Otherwise: go to CHECK.
- CHECK: occ_req=1 with occ_x=x_cand and occ_y=y_cand, held stable until occ_ack=1.
  - occ_ack=1, occ_hit=0: load food_x/food_y, food_valid=1, spawn_done pulse, busy=0, go to IDLE.
  - occ_ack=1, occ_hit=1: tries+1, reload the counter, go to WAIT_X.
- occ_req deasserts the cycle after occ_ack. occ_ack arriving while occ_req=0 is ignored.
- tries is a 5-bit counter that saturates at 31.
- Coordinate comparisons are unsigned at native width; there is no modulo folding. Rejection sampling is the only mapping.
- Reset (including mid-spawn): state=IDLE, busy=0, food_valid=0, food_x=0, food_y=0, occ_req=0, spawn_done=0, spawn_fail=0, tries=0, counter=0. Any in-flight query is abandoned.

## Timing
- Best-case latency from spawn_req to spawn_done is 2·SAMPLE_PERIOD + 1 + L cycles, where L is the occ_ack delay in cycles after occ_req rises (L ≥ 0).
- With defaults and a same-cycle ack, that is 21 cycles.
- Each rejection adds SAMPLE_PERIOD cycles (Y-range reject) or 2·SAMPLE_PERIOD + 1 + L cycles (occupancy hit).
- food_x, food_y and food_valid update on the same edge that spawn_done rises. They are registered outputs with no combinational path from inputs.
- spawn_req arriving on the same cycle as reset: reset wins.

## Configuration
- FOOD_FALLBACK_SCAN_EN defined:
  - When tries reaches MAX_TRIES on a reject, go to SCAN with cursor (0,0).
  - Each cursor cell is issued via the CHECK handshake.
  - On a hit, advance the cursor row-major; X wraps at GRID_W-1 and increments Y.
  - First free cell is accepted exactly as in CHECK.
  - If the cursor passes (GRID_W-1, GRID_H-1) with every cell a hit: spawn_fail pulse, food_valid=0, busy=0, go to IDLE.
- FOOD_FALLBACK_SCAN_EN undefined:
  - No SCAN state; MAX_TRIES is unused.
  - Random retries continue indefinitely.
  - spawn_fail is tied to 0.

## Structure
- Shared package cobra_pkg holds:
  - GRID_W and GRID_H constants.
  - typedefs cell_x_t (6 bits) and cell_y_t (5 bits).
  - enum spawner_state_t.
- Sub-module sample_timer: the SAMPLE_PERIOD countdown, with a load input and a one-cycle tick output. It is reused by other consumers of the LFSR.

## Test plan
- Reset, then drive rnd=10'h005 held steady, spawn_req pulse, occ_ack=1 and occ_hit=0 in the same cycle -> spawn_done at cycle 21; food_x=5, food_y=5, food_valid=1.
- First X sample rnd[5:0]=45 (reject), next X sample 12, Y sample 7 -> exactly one extra SAMPLE_PERIOD of latency; food=(12,7).
- Y sample 31 (≥30, reject), then Y sample 3 -> X candidate retained; food Y=3.
- First query answered occ_hit=1, second candidate (8,9) answered free -> occ_req deasserts between queries; food=(8,9).
- With FOOD_FALLBACK_SCAN_EN, occ_hit=1 everywhere except cell (2,1) -> after 16 tries a scan starts and food=(2,1). With every cell hit -> spawn_fail pulse and food_valid=0.
- Assert reset during CHECK with occ_req=1 -> next cycle busy=0, occ_req=0, food_valid=0; a second spawn_req issued while busy is ignored.
